// File: rtl/pagerank_pkg.sv
// Shared types and defaults for the PageRank gather stage.
package pagerank_pkg;

  typedef logic [63:0] rank_t;
  typedef logic [31:0] node_id_t;

  localparam int FRAC_BITS = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    APPLY = 2'd2,
    DONE  = 2'd3
  } gather_state_t;

endpackage

// File: rtl/pagerank_damp_apply.sv
// Combinational damping: rank = sat64(BASE_TERM + ((acc * DAMPING) >> FRAC_BITS)).
module pagerank_damp_apply
  import pagerank_pkg::*;
#(
  parameter int          FRAC_BITS_P = FRAC_BITS,
  parameter logic [31:0] DAMPING     = 32'hD999_999A,
  parameter logic [63:0] BASE_TERM   = 64'h0000_0000_0999_9999
) (
  input  logic [63:0] acc,
  output logic [63:0] rank
);

  logic [95:0] product;
  logic [63:0] scaled;
  logic [64:0] sum;

  always_comb begin
    product = {32'd0, acc} * {64'd0, DAMPING};
    scaled  = 64'(product >> FRAC_BITS_P);
    sum     = {1'b0, BASE_TERM} + {1'b0, scaled};
    rank    = sum[64] ? 64'hFFFF_FFFF_FFFF_FFFF : sum[63:0];
  end

endmodule

// File: rtl/pagerank_gather.sv
// Gather stage: accumulates scatter contributions per node, then streams damped ranks.
// valid/ready: a beat or rank transfers on a rising edge where valid and ready are both
// high; the sender holds its data stable until that edge.
module pagerank_gather
  import pagerank_pkg::*;
#(
  parameter int          NODES_IN_PARTITION = 4,
  parameter int          FRAC_BITS_P        = FRAC_BITS,
  parameter logic [31:0] DAMPING            = 32'hD999_999A,
  parameter logic [63:0] BASE_TERM          = 64'h0000_0000_0999_9999
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pagerank_enable,
  input  logic        in_valid,
  input  logic [31:0] in_node_id,
  input  logic [63:0] in_contrib,
  output logic        in_ready,
  input  logic        scatter_done,
  output logic        out_valid,
  output logic [31:0] out_node_id,
  output logic [63:0] out_pagerank,
  input  logic        out_ready,
  output logic        gather_complete,
  output logic        id_error,
  output logic        sat_error,
  output logic [1:0]  fsm_state
);

  localparam int          IDX_W = (NODES_IN_PARTITION > 1) ? $clog2(NODES_IN_PARTITION) : 1;
  localparam logic [31:0] N_ID  = 32'(NODES_IN_PARTITION);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NODES_IN_PARTITION - 1);

  gather_state_t    state;
  rank_t            acc [NODES_IN_PARTITION];
  logic [IDX_W-1:0] k;
  logic [IDX_W-1:0] beat_idx;
  logic [64:0]      beat_sum;
  logic             beat_fire;
  logic             beat_in_range;
  rank_t            damped;

  assign fsm_state     = state;
  assign beat_fire     = in_valid && in_ready;
  assign beat_in_range = in_node_id < N_ID;
  assign beat_idx      = in_node_id[IDX_W-1:0];
  assign beat_sum      = {1'b0, acc[beat_idx]} + {1'b0, in_contrib};

  pagerank_damp_apply #(
    .FRAC_BITS_P (FRAC_BITS_P),
    .DAMPING     (DAMPING),
    .BASE_TERM   (BASE_TERM)
  ) u_damp (
    .acc  (acc[k]),
    .rank (damped)
  );

  // Accumulators are frozen in APPLY, so the damped value for node k is stable while stalled.
  assign out_pagerank = out_valid ? damped : 64'd0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      for (int i = 0; i < NODES_IN_PARTITION; i++) acc[i] <= '0;
      k               <= '0;
      in_ready        <= 1'b0;
      out_valid       <= 1'b0;
      out_node_id     <= '0;
      gather_complete <= 1'b0;
      id_error        <= 1'b0;
      sat_error       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (pagerank_enable) begin
            for (int i = 0; i < NODES_IN_PARTITION; i++) acc[i] <= '0;
            state           <= ACCUM;
            k               <= '0;
            in_ready        <= 1'b1;
            gather_complete <= 1'b0;
            id_error        <= 1'b0;
            sat_error       <= 1'b0;
          end
        end
        ACCUM: begin
          if (beat_fire) begin
            if (!beat_in_range) begin
              id_error <= 1'b1;
            end else if (beat_sum[64]) begin
              acc[beat_idx] <= 64'hFFFF_FFFF_FFFF_FFFF;
              sat_error     <= 1'b1;
            end else begin
              acc[beat_idx] <= beat_sum[63:0];
            end
          end
          if (scatter_done) begin
            state       <= APPLY;
            in_ready    <= 1'b0;
            out_valid   <= 1'b1;
            out_node_id <= '0;
            k           <= '0;
          end
        end
        APPLY: begin
          if (out_ready) begin
            if (k == LAST) begin
              state           <= DONE;
              out_valid       <= 1'b0;
              out_node_id     <= '0;
              gather_complete <= 1'b1;
            end else begin
              k           <= k + 1'b1;
              out_node_id <= 32'(k) + 32'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pagerank_gather.sv
// Bench for pagerank_gather: directed scenarios plus random back-to-back beats.
module tb_pagerank_gather;
  import pagerank_pkg::*;

  localparam int          N     = 4;
  localparam logic [31:0] DAMP  = 32'h8000_0000;
  localparam logic [63:0] BASE  = 64'h2000_0000;

  logic        clk;
  logic        reset;
  logic        pagerank_enable;
  logic        in_valid;
  logic [31:0] in_node_id;
  logic [63:0] in_contrib;
  logic        in_ready;
  logic        scatter_done;
  logic        out_valid;
  logic [31:0] out_node_id;
  logic [63:0] out_pagerank;
  logic        out_ready;
  logic        gather_complete;
  logic        id_error;
  logic        sat_error;
  logic [1:0]  fsm_state;

  logic [63:0] exp_q[$];
  logic [31:0] exp_id_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  pagerank_gather #(
    .NODES_IN_PARTITION (N),
    .DAMPING            (DAMP),
    .BASE_TERM          (BASE)
  ) dut (
    .clock           (clk),
    .reset           (reset),
    .pagerank_enable (pagerank_enable),
    .in_valid        (in_valid),
    .in_node_id      (in_node_id),
    .in_contrib      (in_contrib),
    .in_ready        (in_ready),
    .scatter_done    (scatter_done),
    .out_valid       (out_valid),
    .out_node_id     (out_node_id),
    .out_pagerank    (out_pagerank),
    .out_ready       (out_ready),
    .gather_complete (gather_complete),
    .id_error        (id_error),
    .sat_error       (sat_error),
    .fsm_state       (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // reference model of the damping function, done in 128-bit arithmetic
  function automatic logic [63:0] ref_f(input logic [63:0] a);
    logic [127:0] p;
    p = {64'd0, a} * {96'd0, DAMP};
    p = (p >> 32) + {64'd0, BASE};
    if (p[127:64] != 64'd0) return 64'hFFFF_FFFF_FFFF_FFFF;
    return p[63:0];
  endfunction

  // driver tasks
  task automatic start();
    pagerank_enable = 1'b1;
    tick();
    pagerank_enable = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] id, input logic [63:0] c, input logic done);
    in_valid     = 1'b1;
    in_node_id   = id;
    in_contrib   = c;
    scatter_done = done;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL in_ready_accum: got %b expected 1", in_ready);
    end
    tick();
    in_valid     = 1'b0;
    scatter_done = 1'b0;
  endtask

  task automatic end_scatter();
    scatter_done = 1'b1;
    tick();
    scatter_done = 1'b0;
  endtask

  task automatic push_all(input logic [63:0] r0, input logic [63:0] r1,
                          input logic [63:0] r2, input logic [63:0] r3);
    exp_q.push_back(r0); exp_id_q.push_back(32'd0);
    exp_q.push_back(r1); exp_id_q.push_back(32'd1);
    exp_q.push_back(r2); exp_id_q.push_back(32'd2);
    exp_q.push_back(r3); exp_id_q.push_back(32'd3);
  endtask

  // scoreboard: pops the expected queue on each output transfer
  task automatic drain(input int stall_k, input int stall_n, input logic poke);
    int budget;
    int stall_left;
    logic [31:0] eid;
    logic [63:0] erank;
    budget = 0;
    stall_left = stall_n;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL first_valid_latency: got %b expected 1", out_valid);
    end
    while (exp_q.size() > 0 && budget < 200) begin
      if (out_valid === 1'b1) begin
        eid   = exp_id_q[0];
        erank = exp_q[0];
        n_checks++;
        if (out_node_id !== eid) begin
          n_fail++;
          $display("FAIL out_node_id: got %0d expected %0d", out_node_id, eid);
        end
        n_checks++;
        if (out_pagerank !== erank) begin
          n_fail++;
          $display("FAIL out_pagerank node %0d: got %h expected %h", eid, out_pagerank, erank);
        end
        n_checks++;
        if (gather_complete !== 1'b0) begin
          n_fail++;
          $display("FAIL gather_complete_early: got %b expected 0", gather_complete);
        end
        if (stall_left > 0 && eid == 32'(stall_k)) begin
          out_ready       = 1'b0;
          pagerank_enable = poke;
          stall_left--;
        end else begin
          out_ready       = 1'b1;
          pagerank_enable = 1'b0;
          void'(exp_q.pop_front());
          void'(exp_id_q.pop_front());
        end
      end else begin
        out_ready = 1'b0;
      end
      tick();
      budget++;
    end
    out_ready       = 1'b0;
    pagerank_enable = 1'b0;
    n_checks++;
    if (budget >= 200) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d ranks outstanding, expected 0", exp_q.size());
      exp_q.delete();
      exp_id_q.delete();
    end
    n_checks++;
    if (gather_complete !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL done_flags: gather_complete=%b out_valid=%b expected 1/0",
               gather_complete, out_valid);
    end
    n_checks++;
    if (fsm_state !== DONE || out_pagerank !== 64'd0 || out_node_id !== 32'd0) begin
      n_fail++;
      $display("FAIL done_state: state=%0d rank=%h id=%0d expected 3/0/0",
               fsm_state, out_pagerank, out_node_id);
    end
  endtask

  // scenarios
  task automatic test_reset();
    do_reset();
    n_checks++;
    if (fsm_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d expected 0", fsm_state);
    end
    n_checks++;
    if ({in_ready, out_valid, gather_complete, id_error, sat_error} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000",
               {in_ready, out_valid, gather_complete, id_error, sat_error});
    end
    n_checks++;
    if (out_node_id !== 32'd0 || out_pagerank !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: id=%0d rank=%h expected 0/0", out_node_id, out_pagerank);
    end
  endtask

  task automatic test_basic();
    start();
    send_beat(32'd1, 64'h4000_0000, 1'b0);
    send_beat(32'd1, 64'h4000_0000, 1'b0);
    push_all(64'h2000_0000, 64'h6000_0000, 64'h2000_0000, 64'h2000_0000);
    end_scatter();
    drain(-1, 0, 1'b0);
  endtask

  task automatic test_id_error();
    start();
    send_beat(32'd7, 64'h1000, 1'b0);
    n_checks++;
    if (id_error !== 1'b1 || sat_error !== 1'b0) begin
      n_fail++;
      $display("FAIL id_error_set: id=%b sat=%b expected 1/0", id_error, sat_error);
    end
    push_all(BASE, BASE, BASE, BASE);
    end_scatter();
    drain(-1, 0, 1'b0);
    n_checks++;
    if (id_error !== 1'b1) begin
      n_fail++;
      $display("FAIL id_error_sticky: got %b expected 1", id_error);
    end
    start();
    n_checks++;
    if (id_error !== 1'b0) begin
      n_fail++;
      $display("FAIL id_error_clear: got %b expected 0", id_error);
    end
    push_all(BASE, BASE, BASE, BASE);
    end_scatter();
    drain(-1, 0, 1'b0);
  endtask

  task automatic test_done_same_cycle();
    start();
    push_all(BASE, BASE, 64'h4000_0000, BASE);
    send_beat(32'd2, 64'h4000_0000, 1'b1);
    drain(-1, 0, 1'b0);
  endtask

  task automatic test_stall();
    start();
    send_beat(32'd3, 64'h2000_0000, 1'b0);
    push_all(BASE, BASE, BASE, 64'h3000_0000);
    end_scatter();
    drain(2, 3, 1'b1);
  endtask

  task automatic test_saturate();
    start();
    send_beat(32'd0, 64'hFFFF_FFFF_0000_0000, 1'b0);
    n_checks++;
    if (sat_error !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_error_early: got %b expected 0", sat_error);
    end
    send_beat(32'd0, 64'hFFFF_FFFF_0000_0000, 1'b0);
    n_checks++;
    if (sat_error !== 1'b1 || id_error !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_error_set: sat=%b id=%b expected 1/0", sat_error, id_error);
    end
    push_all(64'h8000_0000_1FFF_FFFF, BASE, BASE, BASE);
    end_scatter();
    drain(-1, 0, 1'b0);
    start();
    n_checks++;
    if (sat_error !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_error_clear: got %b expected 0", sat_error);
    end
    push_all(BASE, BASE, BASE, BASE);
    end_scatter();
    drain(-1, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    start();
    send_beat(32'd0, 64'h4000_0000, 1'b0);
    send_beat(32'd3, 64'h8000_0000, 1'b0);
    do_reset();
    n_checks++;
    if (fsm_state !== IDLE || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_state: state=%0d in_ready=%b expected 0/0", fsm_state, in_ready);
    end
    start();
    push_all(BASE, BASE, BASE, BASE);
    end_scatter();
    drain(-1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [63:0] model_acc [N];
    logic        exp_id_err;
    logic [31:0] id;
    logic [63:0] c;
    for (int round = 0; round < 3; round++) begin
      for (int i = 0; i < N; i++) model_acc[i] = 64'd0;
      exp_id_err = 1'b0;
      start();
      for (int b = 0; b < 12; b++) begin
        id = 32'($urandom_range(0, N));
        c  = {8'd0, 24'($urandom), $urandom};
        if (id < 32'(N)) model_acc[id[1:0]] = model_acc[id[1:0]] + c;
        else exp_id_err = 1'b1;
        send_beat(id, c, (b == 11) ? 1'b1 : 1'b0);
      end
      for (int i = 0; i < N; i++) begin
        exp_q.push_back(ref_f(model_acc[i]));
        exp_id_q.push_back(32'(i));
      end
      n_checks++;
      if (id_error !== exp_id_err) begin
        n_fail++;
        $display("FAIL b2b_id_error round %0d: got %b expected %b", round, id_error, exp_id_err);
      end
      drain(-1, 0, 1'b0);
    end
  endtask

  initial begin
    reset           = 1'b0;
    pagerank_enable = 1'b0;
    in_valid        = 1'b0;
    in_node_id      = 32'd0;
    in_contrib      = 64'd0;
    scatter_done    = 1'b0;
    out_ready       = 1'b0;
    test_reset();
    test_basic();
    test_id_error();
    test_done_same_cycle();
    test_stall();
    test_saturate();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
